register_file_mwp: RTL and testbench

//  Multi-write-port register file for the dual/N-issue writeback stage.

---
 rtl/register_file_mwp_if.sv | 26 ++
 rtl/register_file_mwp.sv | 85 ++++++++
 tb/tb_register_file_mwp.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_mwp_if.sv
// register_file_mwp_if: write/read port bundle of the multi-write-port RF.
// master = writeback/issue side, slave = register file.
interface register_file_mwp_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
) ();
    logic [WRITE_PORTS-1:0]                 write_En;
    logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] write_Addr;
    logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_Data;
    logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  read_Addr;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  data_Out;
    logic                                   init_done;
    logic                                   wr_conflict;

    modport master (
        output write_En, write_Addr, write_Data, read_Addr,
        input  data_Out, init_done, wr_conflict
    );

    modport slave (
        input  write_En, write_Addr, write_Data, read_Addr,
        output data_Out, init_done, wr_conflict
    );
endinterface

// File: rtl/register_file_mwp.sv
// register_file_mwp: N-write/M-read RF with post-reset clear sequencer.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_mwp #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int SIZE        = 64,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
) (
    input logic                clk,
    input logic                rst_n,
    register_file_mwp_if.slave rf
);
    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDR_WIDTH:0]   SIZE_L = (ADDR_WIDTH+1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic                  conflict;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ({1'b0, a} < SIZE_L);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            cnt            <= ADDR_WIDTH'(1);
            rf.init_done   <= 1'b0;
            rf.wr_conflict <= 1'b0;
        end else begin
            rf.wr_conflict <= (state == READY) && conflict;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state        <= READY;
                    rf.init_done <= 1'b1;
                end
            end
        end
    end

    // Ascending port loop: the last (highest-index) matching NBA wins.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (rf.write_En[p] && addr_ok(rf.write_Addr[p]))
                    mem[rf.write_Addr[p]] <= rf.write_Data[p];
            end
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            for (int j = i + 1; j < WRITE_PORTS; j++) begin
                if (rf.write_En[i] && rf.write_En[j] &&
                    addr_ok(rf.write_Addr[i]) &&
                    rf.write_Addr[i] == rf.write_Addr[j])
                    conflict = 1'b1;
            end
        end
    end

    always_comb begin
        rf.data_Out = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            if (rf.init_done && addr_ok(rf.read_Addr[r])) begin
                rf.data_Out[r] = mem[rf.read_Addr[r]];
`ifdef RF_BYPASS_EN
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (rf.write_En[p] && rf.write_Addr[p] == rf.read_Addr[r])
                        rf.data_Out[r] = rf.write_Data[p];
                end
`else
`endif
            end
        end
    end
endmodule

// File: tb/tb_register_file_mwp.sv
// tb_register_file_mwp: directed + random checks of register_file_mwp
// against an array-based reference model.
module tb_register_file_mwp;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int SZ = 64;
    localparam int RP = 3;
    localparam int WP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    register_file_mwp_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .READ_PORTS(RP), .WRITE_PORTS(WP)
    ) rf_if ();

    register_file_mwp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ),
        .READ_PORTS(RP), .WRITE_PORTS(WP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rf(rf_if)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model [SZ];
    int edges = 0;
    bit ready = 1'b0;
    bit exp_conf = 1'b0;

    function automatic bit in_range(int a);
        return a != 0 && a < SZ;
    endfunction

    function automatic logic [DW-1:0] exp_read(int a);
        logic [DW-1:0] v;
        if (!ready || !in_range(a)) return '0;
        v = model[a];
`ifdef RF_BYPASS_EN
        for (int p = 0; p < WP; p++)
            if (rf_if.write_En[p] && int'(rf_if.write_Addr[p]) == a)
                v = rf_if.write_Data[p];
`endif
        return v;
    endfunction

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reads();
        for (int r = 0; r < RP; r++) begin
            int a;
            a = int'(rf_if.read_Addr[r]);
            check($sformatf("read%0d@%0d", r, a),
                  rf_if.data_Out[r], exp_read(a));
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < SZ; a++) model[a] = '0;
        edges = 0;
        ready = 1'b0;
        exp_conf = 1'b0;
    endtask

    task automatic tick();
        int hits [SZ];
        bit c;
        #1 check_reads();
        @(posedge clk);
        hits = '{default: 0};
        c = 1'b0;
        if (rst_n && ready) begin
            for (int p = 0; p < WP; p++) begin
                int a;
                a = int'(rf_if.write_Addr[p]);
                if (rf_if.write_En[p] && in_range(a)) begin
                    hits[a]++;
                    model[a] = rf_if.write_Data[p];
                end
            end
            for (int a = 0; a < SZ; a++) if (hits[a] >= 2) c = 1'b1;
        end
        exp_conf = c;
        if (!rst_n) edges = 0;
        else edges++;
        ready = edges >= SZ - 1;
        #1;
        check("init_done", DW'(rf_if.init_done), DW'(ready));
        check("wr_conflict", DW'(rf_if.wr_conflict), DW'(exp_conf));
    endtask

    task automatic set_w(int p, bit en, int a, logic [DW-1:0] d);
        rf_if.write_En[p]   = en;
        rf_if.write_Addr[p] = AW'(a);
        rf_if.write_Data[p] = d;
    endtask

    task automatic clear_w();
        for (int p = 0; p < WP; p++) set_w(p, 1'b0, 0, '0);
    endtask

    task automatic set_r(int r, int a);
        rf_if.read_Addr[r] = AW'(a);
    endtask

    task automatic run_init();
        for (int i = 1; i <= SZ - 1; i++) begin
            for (int r = 0; r < RP; r++) set_r(r, $urandom_range(0, SZ - 1));
            tick();
            check("init_edge", DW'(rf_if.init_done), DW'(i == SZ - 1));
        end
    endtask

    initial begin
        clear_w();
        set_r(0, 5);
        set_r(1, 7);
        set_r(2, 63);
        #2 rst_n = 1'b0;
        model_reset();
        #10;
        check("rst_init_done", DW'(rf_if.init_done), '0);
        check("rst_wr_conflict", DW'(rf_if.wr_conflict), '0);
        for (int r = 0; r < RP; r++)
            check("rst_data_out", rf_if.data_Out[r], '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Init, with an ignored write to entry 3 on the 10th edge
        for (int i = 1; i <= SZ - 1; i++) begin
            if (i == 10) set_w(0, 1'b1, 3, 32'hA5);
            else clear_w();
            for (int r = 0; r < RP; r++) set_r(r, $urandom_range(0, SZ - 1));
            tick();
            check("init_edge", DW'(rf_if.init_done), DW'(i == SZ - 1));
        end
        clear_w();
        set_r(0, 3);
        #1 check("init_write_ignored", rf_if.data_Out[0], '0);

        set_w(0, 1'b1, 5, 32'hDEADBEEF);
        set_r(0, 5);
        tick();
        clear_w();
        #1 check("wr5_next", rf_if.data_Out[0], 32'hDEADBEEF);

        set_w(0, 1'b1, 9, 32'h1111);
        set_w(1, 1'b1, 9, 32'h2222);
        set_r(1, 9);
        tick();
        check("conflict_hi", DW'(rf_if.wr_conflict), 1);
        clear_w();
        tick();
        check("conflict_lo", DW'(rf_if.wr_conflict), 0);
        check("prio_9", rf_if.data_Out[1], 32'h2222);

        set_w(0, 1'b1, 0, 32'hFFFFFFFF);
        set_w(1, 1'b1, 0, 32'hFFFFFFFF);
        set_r(0, 0);
        tick();
        check("addr0_noconf", DW'(rf_if.wr_conflict), 0);
        check("addr0_read", rf_if.data_Out[0], '0);

        for (int p = 0; p < WP; p++) set_w(p, 1'b1, 20, DW'(32'h100 + p));
        set_r(2, 20);
        tick();
        clear_w();
        #1 check("prio_20", rf_if.data_Out[2], DW'(32'h100 + WP - 1));

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < WP; p++)
                set_w(p, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, SZ - 1)
                                                  : $urandom_range(0, 10),
                      DW'($urandom));
            for (int r = 0; r < RP; r++) set_r(r, $urandom_range(0, 12));
            tick();
        end

        // Mid-cycle reset from READY with entry 7 populated
        set_w(0, 1'b1, 7, 32'h55);
        tick();
        clear_w();
        set_r(0, 7);
        #1 check("pre_rst_7", rf_if.data_Out[0], 32'h55);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("midrst_init_done", DW'(rf_if.init_done), '0);
        check("midrst_read7", rf_if.data_Out[0], '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_init();
        set_r(0, 7);
        #1 check("post_rst_7", rf_if.data_Out[0], '0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
